// File: rtl/std_mult_seq.sv
// std_mult_seq: iterative shift-add unsigned multiplier with a go/done handshake.
// Produces one partial product per clock and no hardware multiplier is inferred.
// The full 2*width product is returned as two words.
//
// Ports:
//   clk    - clock; all state changes on the rising edge
//   reset  - synchronous, active-high reset
//   go     - start/hold request; the caller keeps it high for the whole operation
//   left   - multiplicand (unsigned); sampled only on the start edge
//   right  - multiplier (unsigned); sampled only on the start edge
//   out    - low width bits of left*right (registered)
//   out_hi - high width bits of left*right (registered)
//   done   - one-cycle completion pulse (registered)
module std_mult_seq #(
   parameter int width = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [width-1:0] left,
   input  logic [width-1:0] right,
   output logic [width-1:0] out,
   output logic [width-1:0] out_hi,
   output logic             done
);

   localparam int CNT_W = $clog2(width) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(width - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [width-1:0] a_r;
   logic [width:0]   hi_r;      // MSB holds the carry of the running sum
   logic [width-1:0] lo_r;      // remaining multiplier bits, then product low bits
   logic [CNT_W-1:0] count_r;
   logic [width-1:0] out_r;
   logic [width-1:0] out_hi_r;
   logic             done_r;
   logic [width:0]   t_s;

   // Running sum for this iteration: add the multiplicand when the current multiplier bit is set.
   always_comb begin
      t_s = {(width + 1){1'b0}};
      if (lo_r[0]) begin
         t_s = hi_r + {1'b0, a_r};
      end else begin
         t_s = hi_r;
      end
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= IDLE;
         a_r      <= {width{1'b0}};
         hi_r     <= {(width + 1){1'b0}};
         lo_r     <= {width{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         out_r    <= {width{1'b0}};
         out_hi_r <= {width{1'b0}};
         done_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (go) begin
                  a_r     <= left;
                  lo_r    <= right;
                  hi_r    <= {(width + 1){1'b0}};
                  count_r <= {CNT_W{1'b0}};
                  // A zero operand makes the product trivially zero; skip the iterations.
                  if ((left == {width{1'b0}}) || (right == {width{1'b0}})) begin
                     out_r    <= {width{1'b0}};
                     out_hi_r <= {width{1'b0}};
                     done_r   <= 1'b1;
                     state_r  <= DONE;
                  end else begin
                     state_r <= RUN;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            RUN: begin
               if (go) begin
                  // Shift the {sum, multiplier} pair right by one; the carry bit becomes 0.
                  {hi_r, lo_r} <= {t_s, lo_r} >> 1;
                  count_r      <= count_r + CNT_W'(1);
                  if (count_r == LAST_CNT) begin
                     out_r    <= {t_s[0], lo_r[width-1:1]};
                     out_hi_r <= t_s[width:1];
                     done_r   <= 1'b1;
                     state_r  <= DONE;
                  end else begin
                     state_r <= RUN;
                  end
               end else begin
                  // Abort: drop the partial result, keep the previous outputs.
                  state_r <= IDLE;
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign out    = out_r;
   assign out_hi = out_hi_r;
   assign done   = done_r;

`ifndef SYNTHESIS
   logic idle_s;
   assign idle_s = (state_r == IDLE);

   std_mult_seq_chk #(.width(width)) u_chk (
      .clk    (clk),
      .reset  (reset),
      .idle   (idle_s),
      .go     (go),
      .left   (left),
      .right  (right),
      .out    (out_r),
      .out_hi (out_hi_r),
      .done   (done_r)
   );
`endif

endmodule

// std_mult_seq_chk: simulation-only checker comparing each completed result
// against the exact product of the operands latched on the start edge.
//
// Ports:
//   clk, reset          - same clock and reset as the multiplier
//   idle, go            - identify the start edge
//   left, right         - operands offered to the multiplier
//   out, out_hi, done   - multiplier outputs under check
module std_mult_seq_chk #(
   parameter int width = 32
) (
   input logic             clk,
   input logic             reset,
   input logic             idle,
   input logic             go,
   input logic [width-1:0] left,
   input logic [width-1:0] right,
   input logic [width-1:0] out,
   input logic [width-1:0] out_hi,
   input logic             done
);

   logic [2*width-1:0] la_r;
   logic [2*width-1:0] lb_r;

   // Capture operands on the start edge and check the product on each done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         la_r <= {(2 * width){1'b0}};
         lb_r <= {(2 * width){1'b0}};
      end else begin
         if (idle && go) begin
            la_r <= {{width{1'b0}}, left};
            lb_r <= {{width{1'b0}}, right};
         end else begin
            la_r <= la_r;
            lb_r <= lb_r;
         end
         if (done) begin
            assert ({out_hi, out} == la_r * lb_r)
            else $error("std_mult_seq product wrong: %0h * %0h gave %0h", la_r, lb_r, {out_hi, out});
         end
      end
   end

endmodule

// File: tb/tb_std_mult_seq.sv
module tb_std_mult_seq;

   logic        clk = 1'b0;
   logic        reset8 = 1'b1, go8 = 1'b0;
   logic [7:0]  left8 = 8'd0, right8 = 8'd0, out8, hi8;
   logic        done8;
   logic        reset32 = 1'b1, go32 = 1'b0;
   logic [31:0] left32 = 32'd0, right32 = 32'd0, out32, hi32;
   logic        done32;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   std_mult_seq #(.width(8)) u8 (
      .clk(clk), .reset(reset8), .go(go8), .left(left8), .right(right8),
      .out(out8), .out_hi(hi8), .done(done8));

   std_mult_seq #(.width(32)) u32 (
      .clk(clk), .reset(reset32), .go(go32), .left(left32), .right(right32),
      .out(out32), .out_hi(hi32), .done(done32));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: an operation either finishes after a fixed number of
   // edges with the arithmetic product, or is abandoned when go drops.
   int          m_ph[2];      // 0 waiting, 1 busy, 2 reporting
   int          m_rem[2];
   logic [63:0] m_prod[2];
   logic [31:0] m_out[2], m_hi[2];
   logic        m_done[2];

   task automatic mstep(input int i, input int w, input logic rst, input logic g,
                        input logic [31:0] l, input logic [31:0] r);
      if (rst) begin
         m_ph[i] = 0; m_done[i] = 1'b0; m_out[i] = 32'd0; m_hi[i] = 32'd0;
      end else if (m_ph[i] == 0) begin
         m_done[i] = 1'b0;
         if (g) begin
            m_prod[i] = 64'(l) * 64'(r);
            if (l == 32'd0 || r == 32'd0) begin
               m_ph[i] = 2; m_done[i] = 1'b1; m_out[i] = 32'd0; m_hi[i] = 32'd0;
            end else begin
               m_ph[i] = 1; m_rem[i] = w;
            end
         end
      end else if (m_ph[i] == 1) begin
         if (!g) m_ph[i] = 0;
         else begin
            m_rem[i]--;
            if (m_rem[i] == 0) begin
               m_ph[i]   = 2;
               m_done[i] = 1'b1;
               m_out[i]  = 32'(m_prod[i] & ((64'd1 << w) - 64'd1));
               m_hi[i]   = 32'(m_prod[i] >> w);
            end
         end
      end else begin
         m_ph[i] = 0; m_done[i] = 1'b0;
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      mstep(0, 8, reset8, go8, {24'd0, left8}, {24'd0, right8});
      mstep(1, 32, reset32, go32, left32, right32);
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m8_done", {63'd0, done8}, {63'd0, m_done[0]});
         chk("m8_out", {56'd0, out8}, {32'd0, m_out[0]});
         chk("m8_hi", {56'd0, hi8}, {32'd0, m_hi[0]});
         chk("m32_done", {63'd0, done32}, {63'd0, m_done[1]});
         chk("m32_prod", {hi32, out32}, {m_hi[1], m_out[1]});
      end
   end

   // Start an 8-bit operation at a negedge and count edges until done.
   task automatic run8(input string name, input logic [7:0] l, input logic [7:0] r,
                       input logic [7:0] e_lo, input logic [7:0] e_hi, input int e_edges);
      int n;
      n = 0;
      go8 = 1'b1; left8 = l; right8 = r;
      do begin
         @(negedge clk);
         n++;
         left8 = ~left8;  // operands may change after the start edge
      end while (!done8 && n < 40);
      chk({name, "_lat"}, 64'(n), 64'(e_edges));
      chk({name, "_lo"}, {56'd0, out8}, {56'd0, e_lo});
      chk({name, "_hi"}, {56'd0, hi8}, {56'd0, e_hi});
      go8 = 1'b0;
      @(negedge clk);
      chk({name, "_dlow"}, {63'd0, done8}, 64'd0);
   endtask

   logic [31:0] ca, cb;
   int          last_done;
   int          n;

   initial begin
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("rst8", {47'd0, done8, hi8, out8}, 64'd0);
      chk("rst32", {hi32, out32}, 64'd0);
      chk("rst32_done", {63'd0, done32}, 64'd0);
      reset8 = 1'b0; reset32 = 1'b0;
      @(negedge clk);

      run8("m13x11", 8'd13, 8'd11, 8'd143, 8'h00, 9);
      run8("m255x255", 8'd255, 8'd255, 8'h01, 8'hFE, 9);
      run8("m128x2", 8'd128, 8'd2, 8'h00, 8'h01, 9);
      run8("z0x200", 8'd0, 8'd200, 8'h00, 8'h00, 1);
      run8("z77x0", 8'd77, 8'd0, 8'h00, 8'h00, 1);

      // Abort in the middle of an operation.
      run8("m3x5", 8'd3, 8'd5, 8'd15, 8'd0, 9);
      go8 = 1'b1; left8 = 8'd100; right8 = 8'd100;
      repeat (4) @(negedge clk);  // start edge + 3 RUN edges
      go8 = 1'b0;
      n = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8) n++;
      end
      chk("abort_nodone", 64'(n), 64'd0);
      chk("abort_keep", {56'd0, out8}, 64'd15);
      run8("m7x6", 8'd7, 8'd6, 8'd42, 8'd0, 9);

      // Reset in the middle of an operation with go still high.
      go8 = 1'b1; left8 = 8'd9; right8 = 8'd9;
      repeat (4) @(negedge clk);
      reset8 = 1'b1;
      @(negedge clk);
      chk("rstmid", {47'd0, done8, hi8, out8}, 64'd0);
      reset8 = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!done8 && n < 40);
      chk("rstmid_lat", 64'(n), 64'd9);
      chk("rstmid_out", {48'd0, hi8, out8}, 64'd81);
      go8 = 1'b0;
      @(negedge clk);

      // 32-bit back-to-back operations with go held continuously.
      last_done = 0;
      for (int k = 0; k < 1000; k++) begin
         case (k)
            0: begin ca = 32'hFFFFFFFF; cb = 32'hFFFFFFFF; end
            1: begin ca = 32'hFFFFFFFF; cb = 32'd1; end
            2: begin ca = 32'd1; cb = 32'hFFFFFFFF; end
            3: begin ca = 32'h80000000; cb = 32'd2; end
            default: begin
               ca = $urandom; cb = $urandom;
               if (ca == 32'd0) ca = 32'd1;
               if (cb == 32'd0) cb = 32'hFFFFFFFF;
            end
         endcase
         left32 = ca; right32 = cb; go32 = 1'b1;
         n = 0;
         do begin @(negedge clk); n++; end while (!done32 && n < 40);
         if (n >= 40) chk("r32_timeout", 64'(n), 64'd34);
         chk("r32_prod", {hi32, out32}, 64'(ca) * 64'(cb));
         if (k == 0) chk("r32_ffff", {hi32, out32}, 64'hFFFFFFFE00000001);
         if (k == 3) chk("r32_corner", {hi32, out32}, 64'h0000000100000000);
         if (k > 0) chk("r32_spacing", 64'(cyc - last_done), 64'd34);
         last_done = cyc;
      end
      go32 = 1'b0;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
